adc_frame_reader: RTL and testbench
===================================

Name: adc_frame_reader

Overview:
- Parametrised successor to the single-channel serial ADC bit collector.
- Deserialises a framed serial ADC stream into DATLEN-bit words for up to NCH daisy-chained channels, in either bit order.
- Tags each word with its channel index and buffers words in a small FIFO with a valid/ready output handshake.
- Sits between the ADC pins (already synchronised to clk) and the downstream processing chain.

Parameters:
- DATLEN, 12, bits per ADC sample (2..32).
- NCH, 1, channels per frame (1..16); CHW = max(1, clog2(NCH)).
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- MSB_FIRST, 1, 1 = first serial bit is the word MSB; 0 = first bit is the LSB.

Ports:
- clk  in  1  system clock; all sampling on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable (bit strobe); a bit is taken only on cycles with en=1.
- cs_n  in  1  frame select, active low; high = no frame.
- in  in  1  serial data bit.
- out_data  out  DATLEN  sample word at FIFO head.
- out_ch  out  CHW  channel index of out_data.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when out_valid & out_ready.
- clr_ovf  in  1  clears the ovf flag.
- ovf  out  1  sticky overflow flag.
- frame_err  out  1  short-frame pulse (see Optional Feature).

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; bit counter 0; channel counter 0; shift register 0.
- States:
  - IDLE: waits for a frame. On cs_n=0 & en=1, samples the first bit and goes to SHIFT.
  - SHIFT: samples one bit per en=1 cycle; holds when en=0.
  - DONE: all NCH words received; further bits are ignored.
- Bit order: with MSB_FIRST=1, shift left and insert at bit 0. With MSB_FIRST=0, shift right and insert at bit DATLEN-1.
- Word completion: when the DATLEN-th bit is sampled, {channel counter, word} is pushed into the FIFO on that same edge.
  - Bit counter returns to 0.
  - Channel counter increments.
  - After word NCH-1, go to DONE and wrap the channel counter to 0.
- Latency: first-word fall-through. out_valid is high in the cycle after the edge that sampled the last bit, if the FIFO was empty.
- cs_n=1 in any state: next state IDLE; bit and channel counters cleared; any partial word discarded and never pushed. This takes priority over sampling in the same cycle.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push while full: word dropped, ovf set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the word is stored, out_valid=1 next cycle.
- ovf: sticky until clr_ovf=1. If clr_ovf and a new overflow occur in the same cycle, ovf stays 1 (set wins).
- out_data/out_ch: stable while out_valid=1 and out_ready=0.
- Reset asserted mid-frame or mid-handshake: immediate clear. FIFO contents are lost and out_valid drops asynchronously.

Optional Feature:
- Macro: ADC_FRAME_ERR_EN.
- Defined: frame_err pulses high for exactly one cycle on the edge after cs_n rises while in SHIFT with fewer than NCH complete words. This covers a partial word, or whole words with some channels missing. No pulse when rising from DONE or IDLE.
- Undefined: frame_err is tied to 0 and the detection logic is not built. All other behaviour is identical.

Test Plan:
- DATLEN=12, NCH=2, MSB_FIRST=1, en=1, out_ready=1: shift 0xA5C then 0x3F1 MSB-first in one frame → (0xA5C, ch0) then (0x3F1, ch1). First out_valid is 1 cycle after the 12th bit; frame_err stays 0.
- MSB_FIRST=0, NCH=1: shift bits of 0x123 LSB-first → out_data=0x123, out_ch=0. A 13th bit with cs_n still low → no extra word (DONE).
- FIFO_DEPTH=4, NCH=1, out_ready=0: 5 frames of 0x001..0x005 → ovf=1 after the 5th. Then out_ready=1 drains 0x001..0x004 in order. clr_ovf=1 → ovf=0.
- en toggling 1/0 every cycle during the 0xA5C frame → same word, completed in 24 clk cycles instead of 12.
- With ADC_FRAME_ERR_EN: cs_n rises after 7 bits → no push, frame_err high for 1 cycle. Next full frame of 0x7FF → ch0, 0x7FF (counters restarted).
- rst_n pulsed low after 6 bits, with 2 words queued → out_valid=0 and ovf=0 immediately. A subsequent full frame of 0x800 → (0x800, ch0).

Source files
------------

// File: rtl/adc_frame_reader.sv
// +--------------------------------------------------------------------------+
// | adc_frame_reader                                                         |
// | Framed serial ADC deserialiser: NCH daisy-chained DATLEN-bit words,      |
// | channel-tagged, buffered in a FIFO with a valid/ready output.            |
// | Optional: define ADC_FRAME_ERR_EN to build short-frame detection.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module adc_frame_reader #(
  parameter int DATLEN     = 12,
  parameter int NCH        = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cs_n,
  input  logic              in,
  output logic [DATLEN-1:0] out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_ovf,
  output logic              ovf,
  output logic              frame_err
);

  localparam int BCW = $clog2(DATLEN);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [BCW-1:0] C_LAST_BIT = BCW'(DATLEN - 1);
  localparam logic [CHW-1:0] C_LAST_CH  = CHW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATLEN-1:0] r_shift, w_shift_nxt, w_shift_in;
  logic [BCW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic [CHW-1:0]    r_chcnt, w_chcnt_nxt;
  logic              w_push;

  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_shift_in = {r_shift[DATLEN-2:0], in};
  end else begin : g_lsb_first
    assign w_shift_in = {in, r_shift[DATLEN-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_chcnt  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_chcnt  <= w_chcnt_nxt;
    end
  end

  // Deselect wins over sampling, so a partial word is never pushed.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_chcnt_nxt  = r_chcnt;
    w_push       = 1'b0;
    if (cs_n) begin
      w_state_nxt  = ST_IDLE;
      w_shift_nxt  = '0;
      w_bitcnt_nxt = '0;
      w_chcnt_nxt  = '0;
    end else if (en && (r_state != ST_DONE)) begin
      if (r_bitcnt == C_LAST_BIT) begin
        w_push       = 1'b1;
        w_shift_nxt  = '0;
        w_bitcnt_nxt = '0;
        if (r_chcnt == C_LAST_CH) begin
          w_chcnt_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_chcnt_nxt = r_chcnt + 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end else begin
        w_shift_nxt  = w_shift_in;
        w_bitcnt_nxt = r_bitcnt + 1'b1;
        w_state_nxt  = ST_SHIFT;
      end
    end
  end

  logic [DATLEN-1:0] r_mem_data [FIFO_DEPTH];
  logic [CHW-1:0]    r_mem_ch   [FIFO_DEPTH];
  logic [AW:0]       r_wr, r_rd;
  logic              r_ovf;
  logic              w_empty, w_full, w_pop, w_wr_en, w_ovf_set;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop     = !w_empty && out_ready;
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_ch[i]   <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem_data[r_wr[AW-1:0]] <= w_shift_in;
        r_mem_ch[r_wr[AW-1:0]]   <= r_chcnt;
        r_wr                     <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_ovf <= w_ovf_set || (r_ovf && !clr_ovf);
    end
  end

  assign out_data  = r_mem_data[r_rd[AW-1:0]];
  assign out_ch    = r_mem_ch[r_rd[AW-1:0]];
  assign out_valid = !w_empty;
  assign ovf       = r_ovf;

`ifdef ADC_FRAME_ERR_EN
  // Still in SHIFT means fewer than NCH words arrived before deselect.
  logic r_frame_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= cs_n && (r_state == ST_SHIFT);
    end
  end
  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_reader.sv
// +--------------------------------------------------------------------------+
// | tb_adc_frame_reader                                                      |
// | Two instances (NCH=2 MSB-first, NCH=1 LSB-first) against a frame model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_adc_frame_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic cs_n = 1'b1;
  logic in = 1'b0;
  logic out_ready = 1'b0;
  logic clr_ovf = 1'b0;

  logic [1:0][11:0] w_data;
  logic [1:0]       w_ch, w_valid, w_ovf, w_ferr;

  int n_vec = 0;
  int n_err = 0;

`ifdef ADC_FRAME_ERR_EN
  localparam bit c_ferr_en = 1'b1;
`else
  localparam bit c_ferr_en = 1'b0;
`endif

  always #5 clk = ~clk;

  adc_frame_reader #(.DATLEN(12), .NCH(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .cs_n(cs_n), .in(in),
    .out_data(w_data[0]), .out_ch(w_ch[0:0]), .out_valid(w_valid[0]),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .ovf(w_ovf[0]), .frame_err(w_ferr[0])
  );

  adc_frame_reader #(.DATLEN(12), .NCH(1), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .cs_n(cs_n), .in(in),
    .out_data(w_data[1]), .out_ch(w_ch[1:1]), .out_valid(w_valid[1]),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .ovf(w_ovf[1]), .frame_err(w_ferr[1])
  );

  // Reference model: the bits of the current frame, and per instance the
  // queue of {channel, word} waiting at the output.
  bit         fb[$];
  logic [12:0] mq[2][$];
  bit         m_ovf[2];
  bit         m_ferr[2];
  int         c_nch[2] = '{2, 1};
  bit         c_msb[2] = '{1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] word_of(input int j, input bit msb);
    logic [11:0] w = '0;
    for (int k = 0; k < 12; k++) begin
      if (msb) w[11-k] = fb[12*j+k];
      else     w[k]    = fb[12*j+k];
    end
    return w;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [12:0] h;
      check($sformatf("valid%0d", i), w_valid[i], mq[i].size() > 0);
      if (mq[i].size() > 0) begin
        h = mq[i][0];
        check($sformatf("data%0d", i), w_data[i], h[11:0]);
        check($sformatf("ch%0d", i), w_ch[i], h[12]);
      end
      check($sformatf("ovf%0d", i), w_ovf[i], m_ovf[i]);
      check($sformatf("ferr%0d", i), w_ferr[i], m_ferr[i] & c_ferr_en);
    end
  endtask

  task automatic step(input bit cs, input bit e, input bit b, input bit rdy, input bit clr);
    bit pop[2];
    cs_n = cs; en = e; in = b; out_ready = rdy; clr_ovf = clr;
    for (int i = 0; i < 2; i++) begin
      pop[i]    = (mq[i].size() > 0) && rdy;
      m_ferr[i] = cs && (fb.size() > 0) && (fb.size() < 12 * c_nch[i]);
    end
    if (cs) fb.delete();
    else if (e) fb.push_back(b);
    for (int i = 0; i < 2; i++) begin
      bit push, hit;
      int n = fb.size();
      push = !cs && e && (n % 12 == 0) && (n > 0) && (n <= 12 * c_nch[i]);
      hit  = 1'b0;
      if (pop[i]) void'(mq[i].pop_front());
      if (push) begin
        if (mq[i].size() < 4) mq[i].push_back({1'(n / 12 - 1), word_of(n / 12 - 1, c_msb[i])});
        else hit = 1'b1;
      end
      m_ovf[i] = hit || (m_ovf[i] && !clr);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_msb(input logic [11:0] w, input bit rdy);
    for (int k = 11; k >= 0; k--) step(1'b0, 1'b1, w[k], rdy, 1'b0);
  endtask

  task automatic do_reset();
    cs_n = 1'b1; en = 1'b0;
    rst_n = 1'b0;
    #1;
    fb.delete();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete(); m_ovf[i] = 1'b0; m_ferr[i] = 1'b0;
    end
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] w;
    // Reset state
    for (int i = 0; i < 2; i++) begin m_ovf[i] = 1'b0; m_ferr[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_data_a", w_data[0], 12'h000);
    check("rst_ch_a", w_ch[0], 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Two-channel frame, MSB first
    send_msb(12'hA5C, 1'b1);
    check("tp1_valid", w_valid[0], 1'b1);
    check("tp1_w0", w_data[0], 12'hA5C);
    send_msb(12'h3F1, 1'b1);
    check("tp1_w1", w_data[0], 12'h3F1);
    check("tp1_ch1", w_ch[0], 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp1_noferr", w_ferr[0], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first word on instance b, then a 13th bit that must be ignored
    w = 12'h123;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, w[k], 1'b1, 1'b0);
    check("tp2_word", w_data[1], 12'h123);
    check("tp2_ch", w_ch[1], 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("tp2_done", w_valid[1], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow with consumer stalled, then drain and clear
    for (int f = 1; f <= 5; f++) begin
      send_msb(12'(f), 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("tp3_ovf", w_ovf[0], 1'b1);
    for (int f = 1; f <= 4; f++) begin
      check("tp3_drain", w_data[0], 12'(f));
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("tp3_empty", w_valid[0], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("tp3_clr", w_ovf[0], 1'b0);

    // Enable strobing at half rate
    w = 12'hA5C;
    for (int k = 11; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, w[k], 1'b1, 1'b0);
    end
    check("tp4_word", w_data[0], 12'hA5C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Short frame, then a full frame with restarted counters
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp5_ferr", w_ferr[0], c_ferr_en);
    check("tp5_nopush", w_valid[0], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tp5_pulse1", w_ferr[0], 1'b0);
    send_msb(12'h7FF, 1'b1);
    check("tp5_word", w_data[0], 12'h7FF);
    check("tp5_ch", w_ch[0], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame with words queued
    for (int f = 0; f < 2; f++) begin
      send_msb(12'($urandom), 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    do_reset();
    check("tp6_valid", w_valid[0], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_msb(12'h800, 1'b1);
    check("tp6_word", w_data[0], 12'h800);
    check("tp6_ch", w_ch[0], 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
